// File: rtl/alu_pkg.sv
// Shared definitions for the two-client ALU arbiter: widths, opcodes, FSM states.
package alu_pkg;

   localparam int W       = 8;
   localparam int NUM_REQ = 2;

   // Opcode encoding understood by the shared ALU.
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOT = 3'd5,
      ALU_SHR = 3'd6,
      ALU_SHL = 3'd7
   } alu_op_e;

   // Sequencer states: accept, let the ALU settle, capture, hand back.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_e;

   // One-hot form of a requester index.
   function automatic logic [NUM_REQ-1:0] grant_onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle of the arbiter.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ-1:0][2:0]     req_op;
   logic [NUM_REQ-1:0][W-1:0]   req_a;
   logic [NUM_REQ-1:0][W-1:0]   req_b;
   logic [NUM_REQ-1:0]          resp_valid;
   logic [NUM_REQ-1:0]          resp_ready;
   logic [W-1:0]                resp_data;
   logic                        resp_cy;
   logic                        resp_zero;
   logic [2:0]                  alu_ctrl;
   logic [W-1:0]                alu_a;
   logic [W-1:0]                alu_b;
   logic [W-1:0]                alu_out;
   logic                        alu_cy;
   logic                        alu_zero;

   // Arbiter side.
   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready, alu_out, alu_cy, alu_zero,
      output req_ready, resp_valid, resp_data, resp_cy, resp_zero, alu_ctrl, alu_a, alu_b
   );

   // Clients plus ALU side.
   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready, alu_out, alu_cy, alu_zero,
      input  req_ready, resp_valid, resp_data, resp_cy, resp_zero, alu_ctrl, alu_a, alu_b
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       grant_valid_o
);

   // A lone requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant_valid_o = |valid_i;
      if (valid_i == 2'b11) grant_o = ~last_grant_i;
      else                  grant_o = valid_i[1];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two clients.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   state_e       state_q, state_d;
   logic         gnt_q, gnt_d;
   logic         last_q, last_d;
   logic [2:0]   op_q, op_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] res_q, res_d;
   logic         cy_q, cy_d;
   logic         zero_q, zero_d;

   logic         pick;
   logic         pick_valid;

   rr_arb2 u_rr_arb2 (
      .valid_i       (bus.req_valid),
      .last_grant_i  (last_q),
      .grant_o       (pick),
      .grant_valid_o (pick_valid)
   );

   // Next-state, handshake outputs and register updates for each FSM state.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d        = state_q;
      gnt_d          = gnt_q;
      last_d         = last_q;
      op_d           = op_q;
      a_d            = a_q;
      b_d            = b_q;
      res_d          = res_q;
      cy_d           = cy_q;
      zero_d         = zero_q;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               bus.req_ready = grant_onehot(pick);
               gnt_d         = pick;
               op_d          = bus.req_op[pick];
               a_d           = bus.req_a[pick];
               b_d           = bus.req_b[pick];
               state_d       = EXEC;
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            res_d   = bus.alu_out;
            cy_d    = bus.alu_cy;
            zero_d  = bus.alu_zero;
            state_d = RESP;
         end
         RESP: begin
            bus.resp_valid = grant_onehot(gnt_q);
            if (bus.resp_ready[gnt_q]) begin
               last_d  = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand and result registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every register, datapath included, is reset so the ALU and response outputs are defined from the first cycle.
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.alu_ctrl  = op_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.resp_data = res_q;
   assign bus.resp_cy   = cy_q;
   assign bus.resp_zero = zero_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU. Accepts operation requests (op, A, B) from two clients over valid/ready handshakes, drives the ALU from registered operands, captures result, carry and zero, and returns them to the granted client over a per-client response handshake. It sits between the processor's execute stage and an auxiliary client (address/loop unit), so one combinational ALU serves both.

## Interface
- `NUM_REQ`, 2: number of requesters. Fixed; only 2 supported.
- `W`, 8: operand/result width.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  2  bit i: requester i presents an op
- `req_ready`  out  2  bit i: request i accepted this cycle
- `req_op`  in  2x3  per-requester ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHR A>>B, 7 SHL A<<B)
- `req_a`, `req_b`  in  2x8  per-requester operands
- `resp_valid`  out  2  bit i: response for requester i pending
- `resp_ready`  in  2  bit i: requester i takes the response
- `resp_data`  out  8  result (shared; qualified by `resp_valid`)
- `resp_cy`, `resp_zero`  out  1  carry and zero flags of that result
- `alu_ctrl`  out  3  to ALU
- `alu_a`, `alu_b`  out  8  to ALU
- `alu_out`  in  8  from ALU
- `alu_cy`, `alu_zero`  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: if any `req_valid`, grant one: a single requester wins outright; if both, the one not granted last. Assert `req_ready[g]` for that cycle only (combinational from state and valid). On that edge, latch op/A/B into operand regs and grant index `g`; go EXEC.
- EXEC: operand regs drive `alu_ctrl/alu_a/alu_b`; ALU settles. Go CAPT.
- CAPT: register `alu_out`, `alu_cy`, `alu_zero` into result regs. Go RESP.
- RESP: `resp_valid[g]`=1, other bit 0. When `resp_ready[g]`=1: transaction done; update last-grant to `g`; go IDLE. Otherwise hold all outputs stable.
- No new request accepted outside IDLE; `req_ready` is 0 in EXEC/CAPT/RESP.
- `resp_ready` of the non-granted requester is ignored.
- Arithmetic is the ALU's: result = low 8 bits of the 9-bit op result, carry = bit 8; the arbiter does not alter values.
- `alu_*` outputs hold the last operands outside EXEC (registered, no glitching).

## Timing
- Reset (async, immediate): state IDLE, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_cy`=0, `resp_zero`=0, `alu_ctrl`=0, `alu_a`=0, `alu_b`=0; last-grant=1, so requester 0 wins the first tie.
- Accept at edge N (IDLE, `req_ready` high) -> EXEC in cycle N+1, CAPT N+2, `resp_valid` high from N+3.
- Min throughput: one op per 4 cycles (response taken in first RESP cycle, new accept in the next IDLE cycle).
- Response stall: `resp_valid` and data held indefinitely until `resp_ready`.
- Both valid with last-grant=0: grant 1; alternate while both keep requesting.
- `req_valid` dropped before acceptance: nothing happens, no state change.
- Reset mid-transaction (any non-IDLE state): transaction discarded, no response ever issued for it.

## Structure
- Shared package `alu_pkg`: opcode constants (ALU_ADD..ALU_SHL), width constant W=8, FSM state enum (IDLE/EXEC/CAPT/RESP).
- One sub-module: `rr_arb2` — combinational 2-way round-robin picker (inputs valid[1:0], last_grant; outputs grant index, grant_valid).
- Top holds the FSM, operand/result registers, last-grant register; ALU instantiated outside by the integrator.

## Test plan
- Reset then requester 0 ADD A=200 B=100 -> `req_ready[0]` one cycle, `resp_valid[0]` 3 cycles later, data=44, cy=1, zero=0.
- Both valid simultaneously after reset: r0 SUB 5-5, r1 OR 0x0F|0xF0 -> r0 served first (data=0, zero=1, cy=0), then r1 (data=0xFF, zero=0).
- Both hold valid continuously for 4 ops -> grants alternate 0,1,0,1; one op per 4 cycles with `resp_ready` tied high.
- Response stall: r1 SHL A=0x81 B=1, `resp_ready[1]`=0 for 10 cycles -> `resp_valid[1]` and data=0x02, cy=1 stable throughout; `req_ready` stays 0 for r0 meanwhile; `resp_ready[0]` pulses ignored.
- Reset asserted in CAPT -> all outputs to reset values immediately; after release no `resp_valid` for the dropped op.
- NOT A=0xFF -> data=0x00, zero=1; XOR 0xAA^0xAA -> zero=1.
